// File: rtl/oven_cook_timer.sv
// Cook-time controller: builds a cook time from front-panel buttons, counts it
// down at 1 Hz while driving heater power, and beeps for a few seconds when done.
module oven_cook_timer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int MAX_TIME   = 5999,
    parameter int QUICK_TIME = 30,
    parameter int BEEP_S     = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        add_min,
    input  logic        add_sec10,
    input  logic        start,
    input  logic        stop,
    input  logic        door_open,
    output logic [12:0] current_time,
    output logic        power,
    output logic        done,
    output logic        beep,
    output logic [2:0]  state
);

    localparam int TCW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BCW = (BEEP_S > 0) ? $clog2(BEEP_S + 1) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(CLK_HZ - 1);
    localparam logic [BCW-1:0] BEEP_LAST = BCW'(BEEP_S);
    localparam logic [13:0]    MAX_T14   = 14'(MAX_TIME);
    localparam logic [12:0]    MAX_T     = 13'(MAX_TIME);
    localparam logic [12:0]    QUICK_T   = 13'(QUICK_TIME);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [12:0]      time_q, time_d;
    logic [TCW-1:0]   tickCnt_q, tickCnt_d;
    logic [BCW-1:0]   beepCnt_q, beepCnt_d;
    logic             power_q, power_d;
    logic             done_q, done_d;
    logic             beep_q, beep_d;

    logic [3:0]       btnMeta_q, btnSync_q, btnPrev_q;
    logic             doorMeta_q, doorSync_q;
    logic [3:0]       btnIn, btnRise;
    logic             evStop, evDoor, evStart, evAddMin, evAddSec;
    logic             tick;
    logic [TCW-1:0]   tickNext;
    logic [12:0]      runTime;

    // Bit order {stop, start, add_min, add_sec10}; door is a plain synchronized level.
    assign btnIn   = {stop, start, add_min, add_sec10};
    assign btnRise = btnSync_q & ~btnPrev_q;

    assign evStop   = btnRise[3];
    assign evDoor   = !btnRise[3] && doorSync_q;
    assign evStart  = !btnRise[3] && !doorSync_q && btnRise[2];
    assign evAddMin = !btnRise[3] && !doorSync_q && !btnRise[2] && btnRise[1];
    assign evAddSec = !btnRise[3] && !doorSync_q && !btnRise[2] && !btnRise[1] && btnRise[0];

    function automatic logic [12:0] satAdd(input logic [12:0] base, input logic [13:0] inc);
        logic [13:0] sum;
        sum = {1'b0, base} + inc;
        return (sum > MAX_T14) ? MAX_T : sum[12:0];
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btnMeta_q  <= '0;
            btnSync_q  <= '0;
            btnPrev_q  <= '0;
            doorMeta_q <= 1'b0;
            doorSync_q <= 1'b0;
        end else begin
            btnMeta_q  <= btnIn;
            btnSync_q  <= btnMeta_q;
            btnPrev_q  <= btnSync_q;
            doorMeta_q <= door_open;
            doorSync_q <= doorMeta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        tickCnt_d = tickCnt_q;
        beepCnt_d = beepCnt_q;

        // The tick counter also free-runs in DONE so the beep can be timed in seconds.
        tick     = ((state_q == RUN) || (state_q == DONE)) && (tickCnt_q == TICK_LAST);
        tickNext = tick ? '0 : tickCnt_q + 1'b1;
        runTime  = tick ? time_q - 13'd1 : time_q;

        case (state_q)
            IDLE: begin
                tickCnt_d = '0;
                if (evStart) begin
                    state_d = RUN;
                    time_d  = QUICK_T;
                end else if (evAddMin) begin
                    state_d = SET;
                    time_d  = satAdd(time_q, 14'd60);
                end else if (evAddSec) begin
                    state_d = SET;
                    time_d  = satAdd(time_q, 14'd10);
                end
            end
            SET: begin
                tickCnt_d = '0;
                if (evStop) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (evStart && (time_q != '0)) begin
                    state_d = RUN;
                end else if (evAddMin) begin
                    time_d = satAdd(time_q, 14'd60);
                end else if (evAddSec) begin
                    time_d = satAdd(time_q, 14'd10);
                end
            end
            RUN: begin
                if (evStop || evDoor) begin
                    state_d = PAUSE;
                end else begin
                    tickCnt_d = tickNext;
                    if (tick && (time_q <= 13'd1)) begin
                        state_d   = DONE;
                        time_d    = '0;
                        beepCnt_d = '0;
                    end else if (evAddMin) begin
                        time_d = satAdd(runTime, 14'd60);
                    end else begin
                        time_d = runTime;
                    end
                end
            end
            PAUSE: begin
                if (evStop) begin
                    state_d   = IDLE;
                    time_d    = '0;
                    tickCnt_d = '0;
                end else if (evStart) begin
                    state_d = RUN;
                end else if (evAddMin) begin
                    time_d = satAdd(time_q, 14'd60);
                end else if (evAddSec) begin
                    time_d = satAdd(time_q, 14'd10);
                end
            end
            DONE: begin
                tickCnt_d = tickNext;
                if (tick && (beepCnt_q != BEEP_LAST)) begin
                    beepCnt_d = beepCnt_q + 1'b1;
                end
                if (evStop || evStart) begin
                    state_d   = IDLE;
                    time_d    = '0;
                    tickCnt_d = '0;
                end else if (evAddMin) begin
                    state_d   = SET;
                    time_d    = satAdd(13'd0, 14'd60);
                    tickCnt_d = '0;
                end else if (evAddSec) begin
                    state_d   = SET;
                    time_d    = satAdd(13'd0, 14'd10);
                    tickCnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                time_d    = '0;
                tickCnt_d = '0;
                beepCnt_d = '0;
            end
        endcase

        power_d = (state_d == RUN);
        done_d  = (state_d == DONE);
        beep_d  = (state_d == DONE) && (beepCnt_d != BEEP_LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            time_q    <= '0;
            tickCnt_q <= '0;
            beepCnt_q <= '0;
            power_q   <= 1'b0;
            done_q    <= 1'b0;
            beep_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            tickCnt_q <= tickCnt_d;
            beepCnt_q <= beepCnt_d;
            power_q   <= power_d;
            done_q    <= done_d;
            beep_q    <= beep_d;
        end
    end

    assign current_time = time_q;
    assign power        = power_q;
    assign done         = done_q;
    assign beep         = beep_q;
    assign state        = state_q;

endmodule
